// File: rtl/dp_sequencer.sv
// Multi-cycle control sequencer for a simple datapath.
// Latches one instruction word and walks it through read/exec/writeback.
module dp_sequencer #(
  parameter int ERR_STICKY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] instr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    GET_A,
    GET_B,
    EXEC,
    WIMM,
    WREG,
    DONE
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [15:0] ir;
  logic        err_q;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  logic is_movi;
  logic is_movr;
  logic is_add;
  logic is_cmp;
  logic is_and;
  logic is_mvn;
  logic is_alu;
  logic illegal;
  logic accept;

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_add  = (opcode == 3'b101) && (op == 2'b00);
  assign is_cmp  = (opcode == 3'b101) && (op == 2'b01);
  assign is_and  = (opcode == 3'b101) && (op == 2'b10);
  assign is_mvn  = (opcode == 3'b101) && (op == 2'b11);
  assign is_alu  = is_add | is_and | is_cmp;
  assign illegal = ~(is_movi | is_movr | is_alu | is_mvn);
  assign accept  = (state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ir    <= '0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        ir    <= instr;
        err_q <= 1'b0;
      end else if ((state == DECODE) && illegal) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (start) nxt = DECODE;
      end
      DECODE: begin
        unique case (1'b1)
          is_movi:          nxt = WIMM;
          is_movr | is_mvn: nxt = GET_B;
          is_alu:           nxt = GET_A;
          default:          nxt = DONE;
        endcase
      end
      GET_A: nxt = GET_B;
      GET_B: nxt = EXEC;
      EXEC:  nxt = is_cmp ? DONE : WREG;
      WIMM:  nxt = DONE;
      WREG:  nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    readnum  = 3'b000;
    writenum = 3'b000;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 2'b00;
    shift    = 2'b00;
    ALUop    = 2'b00;
    case (state)
      GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      EXEC: begin
        shift = sh;
        asel  = is_movr;
        ALUop = is_movr ? 2'b00 : op;
        loadc = ~is_cmp;
        loads = is_cmp;
      end
      WIMM: begin
        write    = 1'b1;
        writenum = rn;
        vsel     = 2'b10;
      end
      WREG: begin
        write    = 1'b1;
        writenum = rd;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Non-sticky mode only exposes the flag alongside the done pulse.
  assign err = (ERR_STICKY != 0) ? err_q : (err_q & done);

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed self-checking bench for dp_sequencer.
// Outputs are sampled on the falling clock edge.
module tb_dp_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] instr;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [15:0] sximm5;

  int n_chk;
  int n_fail;

  dp_sequencer #(.ERR_STICKY(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .instr    (instr),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .vsel     (vsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm8   (sximm8),
    .sximm5   (sximm5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [20:0] ctl;
  assign ctl = {write, writenum, readnum, loada, loadb, loadc, loads,
                asel, bsel, vsel, shift, ALUop, done, busy};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  int         lat;
  int         nwr;
  int         na;
  int         nb;
  logic [2:0] wn;
  logic [1:0] vs;
  logic [1:0] alu;
  logic [1:0] shf;
  logic       asl;
  logic       lds;
  logic       ldc;
  logic [2:0] ra;
  logic [2:0] rb;
  logic       e_acc;
  logic       e_done;
  logic       idle_ok;

  // Issue one instruction from IDLE and record what each phase drove.
  task automatic run(input logic [15:0] w);
    lat = 1; nwr = 0; na = 0; nb = 0;
    wn = 3'd0; vs = 2'd0; alu = 2'd0; shf = 2'd0;
    asl = 1'b0; lds = 1'b0; ldc = 1'b0;
    ra = 3'd0; rb = 3'd0;
    e_acc = 1'b1; e_done = 1'b0; idle_ok = 1'b0;
    start = 1'b1;
    instr = w;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (lat == 1) e_acc = err;
      if (loada) begin ra = readnum; na++; end
      if (loadb) begin rb = readnum; nb++; end
      if (loadc | loads) begin
        alu = ALUop; shf = shift; asl = asel; lds = loads; ldc = loadc;
      end
      if (write) begin nwr++; wn = writenum; vs = vsel; end
      if (done) begin e_done = err; break; end
      @(posedge clk);
      lat++;
    end
    @(negedge clk);
    idle_ok = !busy && !done;
  endtask

  int seen_done;

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    start = 1'b0;
    instr = 16'h0000;
    #2;
    chk("reset_ctl", {11'd0, ctl}, 32'h0);
    chk("reset_err", {31'd0, err}, 32'h0);
    chk("reset_imm", {sximm8, sximm5}, 32'h0);

    // Start is held through reset; first edge after release takes it.
    start = 1'b1;
    instr = 16'hD2FB;
    @(negedge clk);
    chk("reset_hold_idle", {11'd0, ctl}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("movi_decode", {11'd0, ctl}, 32'h1);
    step;
    chk("movi_wimm", {27'd0, write, writenum, vsel}, {27'd0, 1'b1, 3'd2, 2'b10});
    chk("movi_imm", {sximm8, sximm5}, {16'hFFFB, 16'hFFFB});
    chk("movi_wimm_done", {31'd0, done}, 32'h0);
    step;
    chk("movi_done", {30'd0, done, write}, {30'd0, 1'b1, 1'b0});
    step;
    chk("movi_idle", {11'd0, ctl}, 32'h0);

    // ADD stepwise; start is also waved while busy and must be ignored.
    start = 1'b1;
    instr = 16'hA168;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("add_decode", {11'd0, ctl}, 32'h1);
    start = 1'b1;
    instr = 16'hFFFF;
    step;
    chk("add_geta", {27'd0, readnum, loada, loadb}, {27'd0, 3'd1, 1'b1, 1'b0});
    step;
    chk("add_getb", {27'd0, readnum, loada, loadb}, {27'd0, 3'd0, 1'b0, 1'b1});
    step;
    chk("add_exec", {24'd0, shift, ALUop, loadc, loads, asel, bsel},
        {24'd0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0});
    start = 1'b0;
    step;
    chk("add_wreg", {26'd0, write, writenum, vsel}, {26'd0, 1'b1, 3'd3, 2'b00});
    step;
    chk("add_done", {30'd0, done, busy}, {30'd0, 1'b1, 1'b1});
    step;
    chk("add_idle", {30'd0, done, busy}, 32'h0);
    chk("busy_ir_kept", {sximm8, sximm5}, {16'h0068, 16'h0008});

    run(16'hC0EB);
    chk("movr_lat", lat, 5);
    chk("movr_exec", {28'd0, alu, asl, ldc}, {28'd0, 2'b00, 1'b1, 1'b1});
    chk("movr_reads", {24'd0, na[3:0], nb[3:0], 1'b0, rb}, {24'd0, 4'd0, 4'd1, 1'b0, 3'd3});
    chk("movr_wr", {24'd0, nwr[3:0], 1'b0, wn}, {24'd0, 4'd1, 1'b0, 3'd7});
    chk("movr_idle", {31'd0, idle_ok}, 32'h1);

    run(16'hB886);
    chk("mvn_lat", lat, 5);
    chk("mvn_exec", {28'd0, alu, asl, ldc}, {28'd0, 2'b11, 1'b0, 1'b1});
    chk("mvn_reads", {24'd0, na[3:0], nb[3:0], 1'b0, rb}, {24'd0, 4'd0, 4'd1, 1'b0, 3'd6});
    chk("mvn_wr", {24'd0, nwr[3:0], 1'b0, wn}, {24'd0, 4'd1, 1'b0, 3'd4});

    run(16'hA900);
    chk("cmp_lat", lat, 5);
    chk("cmp_exec", {28'd0, alu, lds, ldc}, {28'd0, 2'b01, 1'b1, 1'b0});
    chk("cmp_reads", {24'd0, na[3:0], 1'b0, ra}, {24'd0, 4'd1, 1'b0, 3'd1});
    chk("cmp_nowrite", nwr, 0);

    run(16'hB2D5);
    chk("and_lat", lat, 6);
    chk("and_exec", {28'd0, alu, shf}, {28'd0, 2'b10, 2'b10});
    chk("and_reads", {24'd0, 1'b0, ra, 1'b0, rb}, {24'd0, 1'b0, 3'd2, 1'b0, 3'd5});
    chk("and_wr", {24'd0, nwr[3:0], 1'b0, wn}, {24'd0, 4'd1, 1'b0, 3'd6});

    run(16'hE000);
    chk("ill_lat", lat, 2);
    chk("ill_err_done", {31'd0, e_done}, 32'h1);
    chk("ill_nowrite", nwr, 0);
    chk("ill_err_sticky", {31'd0, err}, 32'h1);

    run(16'hD800);
    chk("ill2_err_cleared", {31'd0, e_acc}, 32'h0);
    chk("ill2_lat_err", {lat[15:0], 15'd0, e_done}, {16'd2, 15'd0, 1'b1});

    run(16'hD2FB);
    chk("err_clear_accept", {31'd0, e_acc}, 32'h0);
    chk("movi2_lat", lat, 3);
    chk("movi2_wr", {24'd0, nwr[3:0], 1'b0, wn}, {24'd0, 4'd1, 1'b0, 3'd2});
    chk("movi2_vsel", {30'd0, vs}, 32'h2);

    // Reset asserted during GET_B of an ADD.
    start = 1'b1;
    instr = 16'hA168;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    step;
    step;
    chk("rst_getb", {28'd0, loadb, readnum}, {28'd0, 1'b1, 3'd0});
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", {11'd0, ctl}, 32'h0);
    chk("rst_async_imm", {sximm8, sximm5}, 32'h0);
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      step;
      if (done || busy) seen_done++;
    end
    chk("rst_no_done", seen_done, 0);
    rst_n = 1'b1;
    run(16'hA168);
    chk("post_rst_lat", lat, 6);
    chk("post_rst_wr", {24'd0, nwr[3:0], 1'b0, wn}, {24'd0, 4'd1, 1'b0, 3'd3});
    chk("post_rst_idle", {31'd0, idle_ok}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dp_sequencer.md
DP_SEQUENCER -- requirements
Module: dp_sequencer

Interface
REQ-001 The block SHALL take one parameter: ERR_STICKY, default 1; when 1, err holds until reset or the next accepted start; when 0, err is high only during DONE.
REQ-002 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be exactly:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to execute instr
- instr  in  16  instruction word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  illegal-instruction flag
- readnum  out  3  register-file read index
- writenum  out  3  register-file write index
- write  out  1  register-file write enable
- loada  out  1  A-register load enable
- loadb  out  1  B-register load enable
- loadc  out  1  C-register load enable
- loads  out  1  status-register load enable
- asel  out  1  A operand select (1 = zero)
- bsel  out  1  B operand select (1 = sximm5)
- vsel  out  2  writeback select (00 = C, 01 = PC, 10 = sximm8, 11 = mdata)
- shift  out  2  shifter control
- ALUop  out  2  ALU operation
- sximm8  out  16  sign-extended ir[7:0]
- sximm5  out  16  sign-extended ir[4:0]

Function
REQ-004 Instruction fields SHALL be: opcode = [15:13], op = [12:11], Rn = [10:8], Rd = [7:5], sh = [4:3], Rm = [2:0].
REQ-005 In IDLE with start=1, the block SHALL latch instr into internal register ir and go to DECODE; start SHALL be ignored in every other state.
REQ-006 States SHALL be IDLE, DECODE, GET_A, GET_B, EXEC, WIMM, WREG and DONE; DONE SHALL always return to IDLE.
REQ-007 From DECODE, the FSM SHALL branch on opcode and op as follows:
- 110/10 (MOV imm): WIMM.
- 110/00 (MOV reg): GET_B, EXEC, WREG.
- 101/00 (ADD) and 101/10 (AND): GET_A, GET_B, EXEC, WREG.
- 101/01 (CMP): GET_A, GET_B, EXEC.
- 101/11 (MVN): GET_B, EXEC, WREG.
- Anything else: DONE with err set.
REQ-008 GET_A SHALL drive readnum=Rn and loada=1.
REQ-009 GET_B SHALL drive readnum=Rm and loadb=1.
REQ-010 EXEC SHALL drive shift=sh and bsel=0.
REQ-011 In EXEC, asel SHALL be 1 for MOV reg and 0 otherwise.
REQ-012 In EXEC, ALUop SHALL be 00 for MOV reg and op otherwise.
REQ-013 In EXEC, loadc SHALL be 1 except for CMP, where loads=1 and loadc=0.
REQ-014 WIMM SHALL drive write=1, writenum=Rn and vsel=10.
REQ-015 WREG SHALL drive write=1, writenum=Rd and vsel=00.
REQ-016 Control outputs SHALL be combinational from state and ir only.
REQ-017 In any state where a control output is not asserted by REQ-008..015, it SHALL be 0, or 000 / 00 for vector outputs.
REQ-018 If start is accepted at edge k, done SHALL be high in cycle:
- k+3 for MOV imm
- k+5 for MOV reg, MVN and CMP
- k+6 for ADD and AND
- k+2 for an illegal instruction
REQ-019 busy SHALL fall in the same cycle done falls.
REQ-020 sximm8 and sximm5 SHALL be driven continuously from ir by sign extension.
REQ-021 Accepting a new start SHALL clear a sticky err.
REQ-022 Back-to-back operation SHALL be supported: start held high in the IDLE cycle after DONE is accepted, giving one idle cycle between instructions.

Reset
REQ-023 When rst_n=0, the block SHALL immediately (asynchronously) set state=IDLE, ir=0 and err=0, with all outputs 0.
REQ-024 Reset asserted mid-instruction SHALL abort the instruction, drop write, and never produce done for that instruction.
REQ-025 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-026 Scenario, MOV imm: instr=16'hD2FB (MOV R2,#-5) with a start pulse -> WIMM cycle shows write=1, writenum=2, vsel=10, sximm8=16'hFFFB; done at k+3.
REQ-027 Scenario, ADD: instr=16'hA168 (ADD R3,R1,R0 LSL1) -> readnum 1 then 0; EXEC shows shift=01, ALUop=00, loadc=1; WREG writenum=3; done at k+6.
REQ-028 Scenario, CMP: instr=16'hA900 (CMP R1,R0) -> EXEC shows loads=1, loadc=0; write never asserted; done at k+5.
REQ-029 Scenario, illegal: instr=16'hE000 -> err=1 and done at k+2.
REQ-030 Scenario, sticky err: after the illegal instruction, a legal start -> err clears at acceptance.
REQ-031 Scenario, reset mid-instruction: rst_n pulsed low during GET_B of an ADD -> immediate IDLE, all outputs 0, no done; a start after release executes normally.
REQ-032 Scenario, busy: start asserted while busy -> ignored, and ir is unchanged.
